// File: rtl/mod_fifo_chan_if.sv
// mod_fifo_chan_if: producer/consumer handshake bundle for mod_fifo_chan.
interface mod_fifo_chan_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in [NCH];
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out [NCH];
   modport master (output in_valid, data_in, out_ready, input in_ready, out_valid, data_out);
   modport slave  (input in_valid, data_in, out_ready, output in_ready, out_valid, data_out);
endinterface

// File: rtl/mod_fifo_chan.sv
// mod_fifo_chan: multi-lane valid/ready FIFO with synchronous flush.
// Define MOD_FIFO_LEVEL_EN to add registered level and almost_full outputs.
module mod_fifo_chan #(
   parameter int               WIDTH     = 8,
   parameter int               NCH       = 2,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef MOD_FIFO_LEVEL_EN
   ,
   parameter int               AFULL_THR = DEPTH - 1
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   mod_fifo_chan_if.slave             bus
`ifdef MOD_FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       almost_full
`endif
);
   localparam int              PW   = $clog2(DEPTH);
   localparam int              CW   = $clog2(DEPTH + 1);
   localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH][NCH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count, count_nxt;
   logic             push, pop;
   // Full/empty come from count so a non-power-of-two DEPTH needs no extra pointer bit.
   assign bus.in_ready  = count != FULL;
   assign bus.out_valid = count != '0;
   always_comb begin
      push      = bus.in_valid & bus.in_ready & ~clear;
      pop       = bus.out_valid & bus.out_ready & ~clear;
      count_nxt = clear ? '0 : (push & ~pop) ? count + CW'(1) : (pop & ~push) ? count - CW'(1) : count;
   end
   always_comb
      for (int i = 0; i < NCH; i++) bus.data_out[i] = mem[rd_ptr][i];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < NCH; j++) mem[i][j] <= RESET_VAL;
      end else begin
         count <= count_nxt;
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               for (int j = 0; j < NCH; j++) mem[wr_ptr][j] <= bus.data_in[j];
               wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         end
      end
   end
`ifdef MOD_FIFO_LEVEL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level       <= '0;
         almost_full <= 1'b0;
      end else begin
         level       <= count_nxt;
         almost_full <= ~clear & (int'(count_nxt) >= AFULL_THR);
      end
   end
`endif
endmodule

// File: tb/tb_mod_fifo_chan.sv
// tb_mod_fifo_chan: directed scoreboard bench for mod_fifo_chan (DEPTH=4, NCH=2, WIDTH=8).
module tb_mod_fifo_chan;
   logic clk, rst, clear;
   int   total = 0, bad = 0;
   logic [15:0] q [$];
   mod_fifo_chan_if #(.WIDTH(8), .NCH(2)) bus ();
`ifdef MOD_FIFO_LEVEL_EN
   logic [2:0] level;
   logic       almost_full;
   mod_fifo_chan #(.WIDTH(8), .NCH(2), .DEPTH(4), .RESET_VAL(8'h00), .AFULL_THR(3)) dut (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus), .level(level), .almost_full(almost_full));
`else
   mod_fifo_chan #(.WIDTH(8), .NCH(2), .DEPTH(4), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .clear(clear), .bus(bus));
`endif
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check handshake/data against the queue model, then take the edge.
   task automatic cyc(input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, input logic clr);
      logic acc, pp;
      bus.in_valid   = iv;
      bus.data_in[0] = a;
      bus.data_in[1] = b;
      bus.out_ready  = ordy;
      clear          = clr;
      #1;
      chk("in_ready", {15'd0, bus.in_ready}, {15'd0, q.size() != 4});
      chk("out_valid", {15'd0, bus.out_valid}, {15'd0, q.size() != 0});
`ifdef MOD_FIFO_LEVEL_EN
      chk("level", {13'd0, level}, 16'(q.size()));
      chk("almost_full", {15'd0, almost_full}, {15'd0, q.size() >= 3});
`endif
      acc = iv && q.size() != 4 && !clr;
      pp  = ordy && q.size() != 0 && !clr;
      if (pp) chk("data_out", {bus.data_out[0], bus.data_out[1]}, q.pop_front());
      if (acc) q.push_back({a, b});
      if (clr) q.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] a, b;
      rst = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b1;
      bus.data_in[0] = 8'hAA;
      bus.data_in[1] = 8'hBB;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
      chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("rst_data_out", {bus.data_out[0], bus.data_out[1]}, 16'h0000);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      cyc(0, 8'h00, 8'h00, 1, 0);
      cyc(0, 8'h00, 8'h00, 0, 0);
      // fill, refused fifth push, drain
      cyc(1, 8'h01, 8'h02, 0, 0);
      cyc(1, 8'h03, 8'h04, 0, 0);
      cyc(1, 8'h05, 8'h06, 0, 0);
      cyc(1, 8'h07, 8'h08, 0, 0);
      chk("full_in_ready", {15'd0, bus.in_ready}, 16'd0);
      cyc(1, 8'hAA, 8'hBB, 0, 0);
      repeat (4) cyc(0, 8'h00, 8'h00, 1, 0);
      cyc(0, 8'h00, 8'h00, 1, 0);
      // wrap: six beats through at count <= 2
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         cyc(1, a, b, i != 0, 0);
      end
      cyc(0, 8'h00, 8'h00, 1, 0);
      // simultaneous push/pop at count=1
      cyc(1, 8'h99, 8'h98, 0, 0);
      cyc(1, 8'h11, 8'h22, 1, 0);
      chk("sim_data_out", {bus.data_out[0], bus.data_out[1]}, 16'h1122);
      cyc(0, 8'h00, 8'h00, 1, 0);
      // full with in_valid and out_ready: only the pop happens
      cyc(1, 8'hC1, 8'hC2, 0, 0);
      cyc(1, 8'hC3, 8'hC4, 0, 0);
      cyc(1, 8'hC5, 8'hC6, 0, 0);
      cyc(1, 8'hC7, 8'hC8, 0, 0);
      cyc(1, 8'hAA, 8'hBB, 1, 0);
      chk("full_pop_ready", {15'd0, bus.in_ready}, 16'd1);
      // clear at count=3 overrides the push
      cyc(1, 8'h33, 8'h44, 0, 1);
      chk("clr_out_valid", {15'd0, bus.out_valid}, 16'd0);
      cyc(1, 8'h55, 8'h66, 0, 0);
      cyc(0, 8'h00, 8'h00, 1, 0);
      // level/almost_full: push 3, pop 1, drain
      cyc(1, 8'hD1, 8'hD2, 0, 0);
      cyc(1, 8'hD3, 8'hD4, 0, 0);
      cyc(1, 8'hD5, 8'hD6, 0, 0);
      cyc(0, 8'h00, 8'h00, 1, 0);
      cyc(0, 8'h00, 8'h00, 0, 0);
      repeat (3) cyc(0, 8'h00, 8'h00, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
